// File: rtl/net_argmax_if.sv
// ----------------------------------------------------------------------------
// net_argmax_if: bundles the vector-in and result-out handshakes of net_argmax.
//   y_in       packed float vector, element i at [32*i+31:32*i]
//   in_valid   vector valid (net done pulse)
//   in_ready   argmax idle and able to capture
//   class_idx  index of the largest element
//   max_val    float bits of the largest element
//   out_valid  result valid
//   out_ready  consumer accepts result
//   nan_seen   some scanned element was NaN (only with ARGMAX_NAN_FLAG_EN)
// Modports: slave = argmax block, master = producer/consumer side.
// ----------------------------------------------------------------------------
interface net_argmax_if #(
    parameter int unsigned O  = 4,
    parameter int unsigned IW = 2
);
    logic [32*O-1:0] y_in;
    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   class_idx;
    logic [31:0]     max_val;
    logic            out_valid;
    logic            out_ready;
`ifdef ARGMAX_NAN_FLAG_EN
    logic            nan_seen;
`endif

    modport slave (
        input  y_in, in_valid, out_ready,
`ifdef ARGMAX_NAN_FLAG_EN
        output nan_seen,
`endif
        output in_ready, class_idx, max_val, out_valid
    );

    modport master (
        output y_in, in_valid, out_ready,
`ifdef ARGMAX_NAN_FLAG_EN
        input  nan_seen,
`endif
        input  in_ready, class_idx, max_val, out_valid
    );
endinterface

// File: rtl/net_argmax.sv
// ----------------------------------------------------------------------------
// net_argmax: sequential argmax over O single-precision floats.
// Captures a vector in IDLE, compares one element per cycle in SCAN and holds
// {class_idx, max_val} in DONE until the consumer accepts it.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   net_argmax_if.slave (vector in, result out)
// Optional: define ARGMAX_NAN_FLAG_EN to add bus.nan_seen.
// ----------------------------------------------------------------------------
module net_argmax #(
    parameter int unsigned O  = 4,
    parameter int unsigned IW = 2
) (
    input  logic         clk,
    input  logic         rst,
    net_argmax_if.slave  bus
);
    localparam logic [IW-1:0] LastIdx = IW'(O - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

    state_t          r_state, w_state_next;
    logic [32*O-1:0] r_vec, w_vec_next;
    logic [IW-1:0]   r_cnt, w_cnt_next;
    logic            r_have_best, w_have_best_next;
    logic [31:0]     r_best, w_best_next;
    logic [IW-1:0]   r_best_idx, w_best_idx_next;
    logic [IW-1:0]   r_class_idx, w_class_idx_next;
    logic [31:0]     r_max_val, w_max_val_next;

    logic [31:0]     w_elems [O];
    logic [31:0]     w_elem;
    logic            w_is_nan;
    logic            w_take;

    function automatic logic f_is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // a > b for non-NaN operands; +0 and -0 are equal.
    function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
            return 1'b0;
        end else if (a[31] != b[31]) begin
            return !a[31];
        end else if (!a[31]) begin
            return a[30:0] > b[30:0];
        end else begin
            return a[30:0] < b[30:0];
        end
    endfunction

    always_comb begin
        for (int i = 0; i < int'(O); i++) begin
            w_elems[i] = r_vec[32*i +: 32];
        end
    end

    assign w_elem   = w_elems[r_cnt];
    assign w_is_nan = f_is_nan(w_elem);
    assign w_take   = !w_is_nan && (!r_have_best || f_gt(w_elem, r_best));

    always_comb begin
        w_state_next     = r_state;
        w_vec_next       = r_vec;
        w_cnt_next       = r_cnt;
        w_have_best_next = r_have_best;
        w_best_next      = r_best;
        w_best_idx_next  = r_best_idx;
        w_class_idx_next = r_class_idx;
        w_max_val_next   = r_max_val;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_vec_next       = bus.y_in;
                    w_cnt_next       = '0;
                    w_have_best_next = 1'b0;
                    w_state_next     = StScan;
                end
            end
            StScan: begin
                if (w_take) begin
                    w_best_next      = w_elem;
                    w_best_idx_next  = r_cnt;
                    w_have_best_next = 1'b1;
                end
                w_cnt_next = r_cnt + IW'(1);
                if (r_cnt == LastIdx) begin
                    w_state_next = StDone;
                    w_cnt_next   = '0;
                    // All-NaN vector: report element 0 as is.
                    if (w_have_best_next) begin
                        w_class_idx_next = w_best_idx_next;
                        w_max_val_next   = w_best_next;
                    end else begin
                        w_class_idx_next = '0;
                        w_max_val_next   = w_elems[0];
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_vec       <= '0;
            r_cnt       <= '0;
            r_have_best <= 1'b0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_class_idx <= '0;
            r_max_val   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_vec       <= w_vec_next;
            r_cnt       <= w_cnt_next;
            r_have_best <= w_have_best_next;
            r_best      <= w_best_next;
            r_best_idx  <= w_best_idx_next;
            r_class_idx <= w_class_idx_next;
            r_max_val   <= w_max_val_next;
        end
    end

`ifdef ARGMAX_NAN_FLAG_EN
    logic r_nan_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nan_seen <= 1'b0;
        end else if (r_state == StIdle && bus.in_valid) begin
            r_nan_seen <= 1'b0;
        end else if (r_state == StScan && w_is_nan) begin
            r_nan_seen <= 1'b1;
        end
    end

    assign bus.nan_seen = r_nan_seen;
`endif

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.class_idx = r_class_idx;
    assign bus.max_val   = r_max_val;
endmodule

// File: tb/tb_net_argmax.sv
// ----------------------------------------------------------------------------
// tb_net_argmax: directed vectors with hand-computed results. Stimulus pushes
// expected results into a queue; a negedge monitor pops and compares them
// whenever the DUT presents a result.
// ----------------------------------------------------------------------------
module tb_net_argmax;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    net_argmax_if #(.O(4), .IW(2)) bus ();

    net_argmax #(.O(4), .IW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] val;
        logic        nan;
        int          cap;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hs) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL in_ready_after_hs: got %b want 1", bus.in_ready);
                end
            end
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: idx=%0d val=%h with no result pending",
                             bus.class_idx, bus.max_val);
                end else begin
                    e = q[0];
                    if (!prev_valid) begin
                        checks++;
                        if (cyc - e.cap != 4) begin
                            errors++;
                            $display("FAIL latency: got %0d want 4", cyc - e.cap);
                        end
                    end
                    checks++;
                    if (bus.class_idx !== e.idx) begin
                        errors++;
                        $display("FAIL class_idx: got %0d want %0d", bus.class_idx, e.idx);
                    end
                    checks++;
                    if (bus.max_val !== e.val) begin
                        errors++;
                        $display("FAIL max_val: got %h want %h", bus.max_val, e.val);
                    end
`ifdef ARGMAX_NAN_FLAG_EN
                    checks++;
                    if (bus.nan_seen !== e.nan) begin
                        errors++;
                        $display("FAIL nan_seen: got %b want %b", bus.nan_seen, e.nan);
                    end
`endif
                    checks++;
                    if (bus.in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL in_ready_busy: got %b want 0", bus.in_ready);
                    end
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            prev_hs    = (bus.out_valid === 1'b1) && bus.out_ready;
            prev_valid = (bus.out_valid === 1'b1) && !bus.out_ready;
        end
    end

    task automatic send(input logic [127:0] vec, input logic [1:0] idx,
                        input logic [31:0] val, input logic nan, input bit push);
        int n = 0;
        exp_t x;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got %b want 1", bus.in_ready);
        end
        bus.y_in     = vec;
        bus.in_valid = 1'b1;
        if (push) begin
            x.idx = idx;
            x.val = val;
            x.nan = nan;
            x.cap = cyc + 1;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        int n;
        bus.y_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_class_idx", 32'(bus.class_idx), 32'd0);
        chk("reset_max_val", bus.max_val, 32'd0);
        rst = 1'b0;

        send(128'h3f000000_40000000_bf800000_3f800000, 2'd2, 32'h40000000, 1'b0, 1);
        drain();
        send(128'hc0400000_bf000000_c0000000_bf800000, 2'd2, 32'hbf000000, 1'b0, 1);
        drain();
        send(128'h40000000_3f800000_3f800000_40000000, 2'd0, 32'h40000000, 1'b0, 1);
        drain();
        send(128'hbf800000_bf800000_00000000_80000000, 2'd0, 32'h80000000, 1'b0, 1);
        drain();
        send(128'hbf800000_7f800001_3f800000_7fc00000, 2'd1, 32'h3f800000, 1'b1, 1);
        drain();
        send(128'h7fc00000_7fc00000_7fc00000_7fc00000, 2'd0, 32'h7fc00000, 1'b1, 1);
        drain();
        send(128'hff800000_7f800000_3f800000_ff800000, 2'd2, 32'h7f800000, 1'b0, 1);
        drain();
        send(128'h447a0000_3f800000_00000000_bf800000, 2'd3, 32'h447a0000, 1'b0, 1);
        drain();

        // Backpressure with dropped in_valid pulses.
        bus.out_ready = 1'b0;
        send(128'h3f000000_40000000_bf800000_3f800000, 2'd2, 32'h40000000, 1'b0, 1);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_out_valid_rise", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (i == 2 || i == 6);
            bus.y_in     = 128'hc0400000_bf000000_c0000000_bf800000;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        send(128'h447a0000_3f800000_00000000_bf800000, 2'd3, 32'h447a0000, 1'b0, 1);
        drain();

        // Reset two cycles after capture: scan is aborted, no result appears.
        send(128'hbf800000_bf800000_00000000_80000000, 2'd0, 32'h0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_class_idx", 32'(bus.class_idx), 32'd0);
        chk("rst_max_val", bus.max_val, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_result", 32'(bus.out_valid), 32'd0);
        send(128'h3f000000_40000000_bf800000_3f800000, 2'd2, 32'h40000000, 1'b0, 1);
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors",
                 checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/net_argmax.md
Name: net_argmax

Overview:
- Classification stage directly downstream of the `net` inference block.
- Accepts the net's packed vector of O IEEE-754 single-precision outputs when `done` fires.
- Scans the vector sequentially, one element per cycle, and reports the index and value of the largest element.
- Returns the result over a valid/ready handshake to the consumer (host/result logger).

Parameters:
- O, 4, number of 32-bit float elements in the input vector.
- IW, 2, width of the class index; must satisfy 2^IW >= O (and IW >= 1).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- y_in, input, 32*O, packed float vector; element i occupies bits [32*i+31:32*i].
- in_valid, input, 1, vector valid; driven by the net's `done` pulse.
- in_ready, output, 1, high only in IDLE.
- class_idx, output, IW, index of the maximum element.
- max_val, output, 32, float bits of the maximum element.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- nan_seen, output, 1, present only with ARGMAX_NAN_FLAG_EN.

Behaviour:
- Reset (rst=1 at a rising edge), regardless of state:
  - state=IDLE; class_idx=0, max_val=0, out_valid=0, internal counter=0, nan_seen=0.
  - in_ready=1 after the first edge with rst=0 is not required; in_ready is combinational (state==IDLE), so it is 1 from the reset edge onward.
  - A reset mid-scan aborts the scan; no partial result is ever presented.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture y_in into an internal register, clear cnt and have_best, and go to SCAN.
  - Call this capture edge N.
- SCAN, one element per edge, element cnt compared on edges N+1 .. N+O:
  - If have_best=0 and the element is not NaN, take it: best=elem, idx=cnt, have_best=1.
  - If have_best=1 and elem > best under the compare rules below, take it.
  - cnt increments each edge.
  - On the edge that processes element O-1, go to DONE and register class_idx/max_val from best/idx.
- DONE:
  - out_valid=1 after edge N+O, so latency is exactly O cycles from capture.
  - class_idx and max_val are held stable while out_valid=1.
  - On an edge with out_valid&&out_ready: out_valid=0 and state=IDLE; in_ready=1 in the following cycle.
- in_valid is ignored outside IDLE. A done pulse arriving while busy is dropped; the system guarantees spacing.
- Float compare (a > b), combinational, applied to non-NaN operands only:
  - NaN means exp=8'hFF and mantissa!=0.
  - +0 and -0 compare equal.
  - Signs differ: the positive operand is greater.
  - Both positive: compare bits[30:0] unsigned, larger wins.
  - Both negative: smaller bits[30:0] wins.
  - ±Inf follows naturally from the rules above.
- Ties use strict greater-than, so the lowest index wins.
- NaN elements never win. If all elements are NaN: class_idx=0 and max_val=element 0's bits.
- O=1: class_idx is always 0; latency is 1.

Optional Feature:
- Macro: ARGMAX_NAN_FLAG_EN.
- Defined:
  - Adds output port nan_seen.
  - nan_seen is cleared at capture and set if any scanned element is NaN.
  - It becomes valid with out_valid and is held in DONE.
- Undefined: the port and its logic are absent. Argmax behaviour is identical in both builds.

Test Plan:
- O=4, y_in e0..e3 = 3f800000, bf800000, 40000000, 3f000000, in_valid pulse -> out_valid rises exactly 4 cycles after capture; class_idx=2, max_val=40000000.
- All negative, e0..e3 = bf800000, c0000000, bf000000, c0400000 -> class_idx=2, max_val=bf000000.
- Ties:
  - e0=e3=40000000, e1=e2=3f800000 -> class_idx=0.
  - e0=80000000, e1=00000000, e2=e3=bf800000 -> class_idx=0, max_val=80000000.
- NaN:
  - e0=7fc00000, e1=3f800000, e2=7f800001, e3=bf800000 -> class_idx=1, max_val=3f800000, nan_seen=1 (macro on).
  - All four 7fc00000 -> class_idx=0, max_val=7fc00000.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid pulsed twice meanwhile -> out_valid/class_idx/max_val stable and in_ready=0 throughout; out_ready=1 -> handshake, in_ready=1 next cycle; a new vector then completes normally.
- Reset mid-scan: rst=1 two cycles after capture -> next edge has out_valid=0, class_idx=0, max_val=0, in_ready=1; a fresh vector then gives the correct result with latency 4.
